// File: rtl/ex_alu_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_wb_stage_if
// Brief    : Issue, ALU-result, SR and writeback/forward signals of the
//            ALU writeback stage.
// Revision : 1.0  initial release
// ============================================================================
interface ex_alu_wb_stage_if #(
    parameter int REGID_W = 6
);
    logic               exHold;
    logic               exFlush;
    logic               idValid;
    logic [7:0]         idUIxt;
    logic [REGID_W-1:0] idRegIdRn;
    logic [63:0]        aluOutVal;
    logic [1:0]         aluOutSrST;
    logic               srLoadEn;
    logic [1:0]         srLoadVal;

    logic [1:0]         aluInSrST;
    logic               fwdE1Valid;
    logic [REGID_W-1:0] fwdE1Id;
    logic [63:0]        fwdE1Val;
    logic               fwdE2Valid;
    logic [REGID_W-1:0] fwdE2Id;
    logic [63:0]        fwdE2Val;
    logic               wbEn;
    logic [REGID_W-1:0] wbRegId;
    logic [63:0]        wbVal;
    logic [1:0]         srST;

    modport master (
        output exHold, exFlush, idValid, idUIxt, idRegIdRn,
               aluOutVal, aluOutSrST, srLoadEn, srLoadVal,
        input  aluInSrST, fwdE1Valid, fwdE1Id, fwdE1Val,
               fwdE2Valid, fwdE2Id, fwdE2Val, wbEn, wbRegId, wbVal, srST
    );

    modport slave (
        input  exHold, exFlush, idValid, idUIxt, idRegIdRn,
               aluOutVal, aluOutSrST, srLoadEn, srLoadVal,
        output aluInSrST, fwdE1Valid, fwdE1Id, fwdE1Val,
               fwdE2Valid, fwdE2Id, fwdE2Val, wbEn, wbRegId, wbVal, srST
    );
endinterface
`default_nettype wire

// File: rtl/ex_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_wb_stage
// Brief    : Tracks ALU ops through E1/E2/E3, drives GPR writeback and
//            forwarding, and owns / forwards the architectural SR.ST pair.
// Revision : 1.0  initial release
// ============================================================================
module ex_alu_wb_stage #(
    parameter int ENABLE_GSV = 1,
    parameter int REGID_W    = 6
) (
    input  wire logic         clock,
    input  wire logic         reset,
    ex_alu_wb_stage_if.slave  bus
);

    typedef struct packed {
        logic               vld;
        logic               wg;
        logic               wt;
        logic               ws;
        logic [REGID_W-1:0] id;
    } slot_t;

    slot_t        w_issue;
    logic         w_gpr_op;
    logic         w_t_op;
    logic         w_unused_bits;

    slot_t        r_e1;
    slot_t        r_e2;
    slot_t        r_e3;
    logic [63:0]  r_e2_val;
    logic [63:0]  r_e3_val;
    logic [1:0]   r_e2_st;
    logic [1:0]   r_e3_st;
    logic [1:0]   r_sr;

    logic         w_e3_commit;
    logic [1:0]   w_sr_nxt;
    logic [1:0]   w_fwd_sr;

    assign w_unused_bits = &{1'b0, bus.idUIxt[7:6]};

    // Op class decode, captured at issue so later slots need no opcode.
    always_comb begin
        w_gpr_op = 1'b0;
        w_t_op   = 1'b0;
        case (bus.idUIxt[3:0])
            4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'hF: w_gpr_op = 1'b1;
            4'h2, 4'h3: begin
                w_gpr_op = 1'b1;
                w_t_op   = 1'b1;
            end
            4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE: w_t_op = 1'b1;
            default: begin
                w_gpr_op = 1'b0;
                w_t_op   = 1'b0;
            end
        endcase

        w_issue     = '0;
        w_issue.vld = bus.idValid;
        w_issue.wg  = w_gpr_op && (bus.idRegIdRn != '0);
        w_issue.wt  = w_t_op;
        w_issue.ws  = w_t_op && (ENABLE_GSV != 0) && (bus.idUIxt[5:4] == 2'b11);
        w_issue.id  = bus.idRegIdRn;
    end

    // A held E3 commits only once, on the first cycle the hold is released.
    assign w_e3_commit = r_e3.vld && !bus.exHold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_e1     <= '0;
            r_e2     <= '0;
            r_e3     <= '0;
            r_e2_val <= '0;
            r_e3_val <= '0;
            r_e2_st  <= '0;
            r_e3_st  <= '0;
            r_sr     <= '0;
        end else begin
            if (bus.exFlush) begin
                // Killed E2 would otherwise slide into E3; the old E3 op
                // has already written this cycle when not held.
                r_e1.vld <= 1'b0;
                r_e2.vld <= 1'b0;
                if (!bus.exHold) begin
                    r_e3.vld <= 1'b0;
                end
            end else if (!bus.exHold) begin
                r_e1     <= w_issue;
                r_e2     <= r_e1;
                r_e2_val <= bus.aluOutVal;
                r_e2_st  <= bus.aluOutSrST;
                r_e3     <= r_e2;
                r_e3_val <= r_e2_val;
                r_e3_st  <= r_e2_st;
            end
            r_sr <= w_sr_nxt;
        end
    end

    // Bit 0 is T, bit 1 is S; each resolves its own youngest writer.
    for (genvar b = 0; b < 2; b++) begin : g_sr_bit
        logic w_wr1;
        logic w_wr2;
        logic w_wr3;

        assign w_wr1 = r_e1.vld && ((b == 0) ? r_e1.wt : r_e1.ws);
        assign w_wr2 = r_e2.vld && ((b == 0) ? r_e2.wt : r_e2.ws);
        assign w_wr3 = r_e3.vld && ((b == 0) ? r_e3.wt : r_e3.ws);

        assign w_fwd_sr[b] = w_wr1        ? bus.aluOutSrST[b] :
                             w_wr2        ? r_e2_st[b]        :
                             w_wr3        ? r_e3_st[b]        :
                             bus.srLoadEn ? bus.srLoadVal[b]  :
                                            r_sr[b];

        assign w_sr_nxt[b] = bus.srLoadEn           ? bus.srLoadVal[b] :
                             (w_e3_commit && w_wr3) ? r_e3_st[b]       :
                                                      r_sr[b];
    end

    assign bus.aluInSrST  = w_fwd_sr;
    assign bus.srST       = r_sr;

    assign bus.fwdE1Valid = r_e1.vld && r_e1.wg;
    assign bus.fwdE1Id    = r_e1.id;
    assign bus.fwdE1Val   = bus.aluOutVal;
    assign bus.fwdE2Valid = r_e2.vld && r_e2.wg;
    assign bus.fwdE2Id    = r_e2.id;
    assign bus.fwdE2Val   = r_e2_val;

    assign bus.wbEn       = r_e3.vld && r_e3.wg && !bus.exHold;
    assign bus.wbRegId    = r_e3.id;
    assign bus.wbVal      = r_e3_val;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_alu_wb_stage
// Brief    : Directed table-driven bench for ex_alu_wb_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_alu_wb_stage;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    ex_alu_wb_stage_if #(.REGID_W(6)) bus ();

    ex_alu_wb_stage #(
        .ENABLE_GSV (1),
        .REGID_W    (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [7:0]  ux;
        logic [5:0]  rn;
        logic [63:0] av;
        logic [1:0]  ast;
        logic        ld;
        logic [1:0]  ldv;
        logic        e1v;
        logic [5:0]  e1id;
        logic        e2v;
        logic [63:0] e2val;
        logic        wbe;
        logic [5:0]  wbid;
        logic [63:0] wbv;
        logic [1:0]  insr;
        logic [1:0]  sr;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mk(
        input logic iv, input logic [7:0] ux, input logic [5:0] rn,
        input logic [63:0] av, input logic [1:0] ast,
        input logic ld, input logic [1:0] ldv,
        input logic e1v, input logic [5:0] e1id,
        input logic e2v, input logic [63:0] e2val,
        input logic wbe, input logic [5:0] wbid, input logic [63:0] wbv,
        input logic [1:0] insr, input logic [1:0] sr);
        vec_t v;
        v.iv = iv;   v.ux = ux;     v.rn = rn;   v.av = av;   v.ast = ast;
        v.ld = ld;   v.ldv = ldv;   v.e1v = e1v; v.e1id = e1id;
        v.e2v = e2v; v.e2val = e2val;
        v.wbe = wbe; v.wbid = wbid; v.wbv = wbv; v.insr = insr; v.sr = sr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic iv, input logic [7:0] ux, input logic [5:0] rn,
                          input logic [63:0] av, input logic [1:0] ast,
                          input logic hold, input logic flush,
                          input logic ld, input logic [1:0] ldv);
        bus.idValid    = iv;
        bus.idUIxt     = ux;
        bus.idRegIdRn  = rn;
        bus.aluOutVal  = av;
        bus.aluOutSrST = ast;
        bus.exHold     = hold;
        bus.exFlush    = flush;
        bus.srLoadEn   = ld;
        bus.srLoadVal  = ldv;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        set_in(0, 8'h00, 6'd0, 64'h0, 2'b00, 0, 0, 0, 2'b00);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_in();

        // Opcodes: 00 ADD, 02 ADC, 08 CMPEQ, 38 packed CMPEQ, 0B NOR, 0C TST
        //          iv ux     rn    av          ast   ld ldv | e1v id e2v e2val     wbe id wbv      insr  sr
        tv[0]  = mk(1, 8'h00, 6'd5, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b00, 2'b00);
        tv[1]  = mk(1, 8'h08, 6'd0, 64'h1234,   2'b00, 0, 2'b00, 1, 5, 0, 64'h0,    0, 0, 64'h0,    2'b00, 2'b00);
        tv[2]  = mk(1, 8'h02, 6'd7, 64'h0,      2'b01, 0, 2'b00, 0, 0, 1, 64'h1234, 0, 0, 64'h0,    2'b01, 2'b00);
        tv[3]  = mk(1, 8'h02, 6'd8, 64'hAAAA,   2'b01, 0, 2'b00, 1, 7, 0, 64'h0,    1, 5, 64'h1234, 2'b01, 2'b00);
        tv[4]  = mk(1, 8'h02, 6'd9, 64'hBBBB,   2'b01, 0, 2'b00, 1, 8, 1, 64'hAAAA, 0, 0, 64'h0,    2'b01, 2'b00);
        tv[5]  = mk(0, 8'h00, 6'd0, 64'hCCCC,   2'b00, 0, 2'b00, 1, 9, 1, 64'hBBBB, 1, 7, 64'hAAAA, 2'b00, 2'b01);
        tv[6]  = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 1, 64'hCCCC, 1, 8, 64'hBBBB, 2'b00, 2'b01);
        tv[7]  = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    1, 9, 64'hCCCC, 2'b00, 2'b01);
        tv[8]  = mk(1, 8'h38, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b00, 2'b00);
        tv[9]  = mk(0, 8'h00, 6'd0, 64'h0,      2'b11, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b11, 2'b00);
        tv[10] = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b11, 2'b00);
        tv[11] = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b11, 2'b00);
        tv[12] = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b11, 2'b11);
        tv[13] = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 1, 2'b10, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b10, 2'b11);
        tv[14] = mk(1, 8'h0B, 6'd3, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b10, 2'b10);
        tv[15] = mk(1, 8'h00, 6'd0, 64'h5555,   2'b11, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b10, 2'b10);
        tv[16] = mk(0, 8'h00, 6'd0, 64'h6666,   2'b11, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b10, 2'b10);
        tv[17] = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b10, 2'b10);
        tv[18] = mk(0, 8'h00, 6'd0, 64'h0,      2'b00, 0, 2'b00, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2'b10, 2'b10);

        #12;
        chk("reset wbEn",       64'(bus.wbEn),       64'h0);
        chk("reset wbVal",      bus.wbVal,           64'h0);
        chk("reset wbRegId",    64'(bus.wbRegId),    64'h0);
        chk("reset srST",       64'(bus.srST),       64'h0);
        chk("reset aluInSrST",  64'(bus.aluInSrST),  64'h0);
        chk("reset fwdE1Valid", 64'(bus.fwdE1Valid), 64'h0);
        chk("reset fwdE2Valid", 64'(bus.fwdE2Valid), 64'h0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            set_in(tv[i].iv, tv[i].ux, tv[i].rn, tv[i].av, tv[i].ast, 0, 0, tv[i].ld, tv[i].ldv);
            #2;
            chk($sformatf("row%0d fwdE1Valid", i), 64'(bus.fwdE1Valid), 64'(tv[i].e1v));
            if (tv[i].e1v) begin
                chk($sformatf("row%0d fwdE1Id", i),  64'(bus.fwdE1Id), 64'(tv[i].e1id));
                chk($sformatf("row%0d fwdE1Val", i), bus.fwdE1Val,     tv[i].av);
            end
            chk($sformatf("row%0d fwdE2Valid", i), 64'(bus.fwdE2Valid), 64'(tv[i].e2v));
            if (tv[i].e2v)
                chk($sformatf("row%0d fwdE2Val", i), bus.fwdE2Val, tv[i].e2val);
            chk($sformatf("row%0d wbEn", i), 64'(bus.wbEn), 64'(tv[i].wbe));
            if (tv[i].wbe) begin
                chk($sformatf("row%0d wbRegId", i), 64'(bus.wbRegId), 64'(tv[i].wbid));
                chk($sformatf("row%0d wbVal", i),   bus.wbVal,        tv[i].wbv);
            end
            chk($sformatf("row%0d aluInSrST", i), 64'(bus.aluInSrST), 64'(tv[i].insr));
            chk($sformatf("row%0d srST", i),      64'(bus.srST),      64'(tv[i].sr));
            step();
        end

        // Hold: op held in E2 for two cycles, then held again in E3.
        set_in(1, 8'h00, 6'd4, 64'h0, 2'b00, 0, 0, 0, 2'b00); #2; step();
        set_in(0, 8'h00, 6'd0, 64'hDEAD, 2'b00, 0, 0, 0, 2'b00); #2;
        chk("hold e1 valid", 64'(bus.fwdE1Valid), 64'h1); step();
        set_in(0, 8'h00, 6'd0, 64'h0, 2'b00, 1, 0, 0, 2'b00); #2;
        chk("hold c2 wbEn", 64'(bus.wbEn), 64'h0);
        chk("hold c2 fwdE2Val", bus.fwdE2Val, 64'hDEAD); step();
        #2;
        chk("hold c3 wbEn", 64'(bus.wbEn), 64'h0);
        chk("hold c3 fwdE2Valid", 64'(bus.fwdE2Valid), 64'h1); step();
        idle_in(); #2;
        chk("hold c4 wbEn", 64'(bus.wbEn), 64'h0); step();
        bus.exHold = 1'b1; #2;
        chk("hold c5 wbEn e3 held", 64'(bus.wbEn), 64'h0); step();
        bus.exHold = 1'b0; #2;
        chk("hold c6 wbEn", 64'(bus.wbEn), 64'h1);
        chk("hold c6 wbRegId", 64'(bus.wbRegId), 64'd4);
        chk("hold c6 wbVal", bus.wbVal, 64'hDEAD); step();
        #2;
        chk("hold c7 single wb", 64'(bus.wbEn), 64'h0); step();

        // Flush with ops in E1 and E2 and a committed op in E3.
        set_in(1, 8'h00, 6'd10, 64'h0, 2'b00, 0, 0, 0, 2'b00); #2; step();
        set_in(1, 8'h00, 6'd1, 64'hA0, 2'b00, 0, 0, 0, 2'b00); #2; step();
        set_in(1, 8'h00, 6'd2, 64'h01, 2'b00, 0, 0, 0, 2'b00); #2; step();
        set_in(1, 8'h00, 6'd3, 64'h02, 2'b00, 0, 1, 0, 2'b00); #2;
        chk("flush e3 wbEn", 64'(bus.wbEn), 64'h1);
        chk("flush e3 wbRegId", 64'(bus.wbRegId), 64'd10);
        chk("flush e3 wbVal", bus.wbVal, 64'hA0);
        chk("flush pre e1", 64'(bus.fwdE1Valid), 64'h1);
        chk("flush pre e2", 64'(bus.fwdE2Valid), 64'h1); step();
        idle_in(); #2;
        chk("flush post e1", 64'(bus.fwdE1Valid), 64'h0);
        chk("flush post e2", 64'(bus.fwdE2Valid), 64'h0);
        chk("flush c4 wbEn", 64'(bus.wbEn), 64'h0); step();
        #2; chk("flush c5 wbEn", 64'(bus.wbEn), 64'h0); step();
        #2; chk("flush c6 wbEn", 64'(bus.wbEn), 64'h0); step();

        // srLoadEn colliding with an E3 TST flag write.
        set_in(0, 8'h00, 6'd0, 64'h0, 2'b00, 0, 0, 1, 2'b00); #2; step();
        set_in(1, 8'h0C, 6'd0, 64'h0, 2'b00, 0, 0, 0, 2'b00); #2;
        chk("srld clear srST", 64'(bus.srST), 64'h0); step();
        set_in(0, 8'h00, 6'd0, 64'h0, 2'b01, 0, 0, 0, 2'b00); #2; step();
        idle_in(); #2; step();
        set_in(0, 8'h00, 6'd0, 64'h0, 2'b00, 0, 0, 1, 2'b10); #2;
        chk("srld e3 fwd aluInSrST", 64'(bus.aluInSrST), 64'h3);
        chk("srld tst wbEn", 64'(bus.wbEn), 64'h0); step();
        idle_in(); #2;
        chk("srld priority srST", 64'(bus.srST), 64'h2); step();

        // Reset asserted while an op sits in E3.
        set_in(1, 8'h00, 6'd5, 64'h0, 2'b00, 0, 0, 0, 2'b00); #2; step();
        set_in(0, 8'h00, 6'd0, 64'h77, 2'b00, 0, 0, 0, 2'b00); #2; step();
        idle_in(); #2; step();
        #1;
        chk("rst pre wbEn", 64'(bus.wbEn), 64'h1);
        reset = 1'b1;
        #1;
        chk("rst mid wbEn", 64'(bus.wbEn), 64'h0);
        chk("rst mid srST", 64'(bus.srST), 64'h0);
        chk("rst mid wbVal", bus.wbVal, 64'h0);
        chk("rst mid aluInSrST", 64'(bus.aluInSrST), 64'h0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("rst post%0d wbEn", k), 64'(bus.wbEn), 64'h0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
